// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module   : pipeline_sequencer
// Brief    : Run/stall/drain/halt controller for the 5-stage MIPS pipeline.
//            Optional single-step mode: define PIPE_SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_halt,
`ifdef PIPE_SINGLE_STEP_EN
  input  logic             i_step_mode,
  input  logic             i_step,
`endif
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_back_en,
  output logic             o_running,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int c_DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_RUN    = 2'd1;
  localparam logic [1:0] c_ST_DRAIN  = 2'd2;
  localparam logic [1:0] c_ST_HALTED = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_DW-1:0] r_drain_cnt;
  logic [c_DW-1:0] w_drain_nxt;
  logic [CNT_W-1:0] r_cycle_count;
  logic            w_adv;

  // w_adv low freezes RUN/DRAIN completely: no enables, no state progress.
`ifdef PIPE_SINGLE_STEP_EN
  assign w_adv = !i_step_mode || i_step;
`else
  assign w_adv = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= c_ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (i_start) w_state_nxt = c_ST_RUN;
      end
      c_ST_RUN: begin
        // A HALT under a flush sits on the wrong path and is discarded.
        if (w_adv && !i_flush && i_halt) begin
          w_state_nxt = c_ST_DRAIN;
          w_drain_nxt = c_DW'(DRAIN_CYCLES - 1);
        end
      end
      c_ST_DRAIN: begin
        if (w_adv) begin
          if (r_drain_cnt == '0) w_state_nxt = c_ST_HALTED;
          else                   w_drain_nxt = r_drain_cnt - c_DW'(1);
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_back_en     = 1'b0;
    o_running     = (r_state == c_ST_RUN);
    o_halted      = (r_state == c_ST_HALTED);
    case (r_state)
      c_ST_RUN: begin
        if (w_adv) begin
          o_back_en = 1'b1;
          if (i_flush) begin
            o_pc_en       = 1'b1;
            o_if_id_en    = 1'b1;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (i_halt || i_stall) begin
            o_id_ex_flush = 1'b1;
          end else begin
            o_pc_en    = 1'b1;
            o_if_id_en = 1'b1;
          end
        end
      end
      c_ST_DRAIN: begin
        if (w_adv) begin
          o_back_en     = 1'b1;
          o_id_ex_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_count <= '0;
    end else if (o_back_en && (r_cycle_count != {CNT_W{1'b1}})) begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  assign o_cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module   : tb_pipeline_sequencer
// Brief    : Scoreboard bench for pipeline_sequencer with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;

  localparam int DRAIN = 4;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic r_clk = 1'b0;
  logic r_rst_n = 1'b0;
  logic r_start = 1'b0, r_stall = 1'b0, r_flush = 1'b0, r_halt = 1'b0;
  logic r_step_mode = 1'b0, r_step = 1'b0;
  logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_flush, w_back_en;
  logic w_running, w_halted;
  logic [CW-1:0] w_cycle_count;

  always #5 r_clk = ~r_clk;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .i_clk         (r_clk),
    .i_rst_n       (r_rst_n),
    .i_start       (r_start),
    .i_stall       (r_stall),
    .i_flush       (r_flush),
    .i_halt        (r_halt),
`ifdef PIPE_SINGLE_STEP_EN
    .i_step_mode   (r_step_mode),
    .i_step        (r_step),
`endif
    .o_pc_en       (w_pc_en),
    .o_if_id_en    (w_if_id_en),
    .o_if_id_flush (w_if_id_flush),
    .o_id_ex_flush (w_id_ex_flush),
    .o_back_en     (w_back_en),
    .o_running     (w_running),
    .o_halted      (w_halted),
    .o_cycle_count (w_cycle_count)
  );

  // Expected word: {pc,if_id_en,if_id_flush,id_ex_flush,back,running,halted,count}
  logic [7+CW-1:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: the program is "started", a HALT has been "seen", and the pipeline
  // has advanced m_since times since; halted after DRAIN such advances.
  bit m_started = 0, m_halt_seen = 0;
  int m_since = 0, m_count = 0;

  task automatic cycle(input bit rn, input bit st, input bit sl, input bit fl,
                       input bit hl, input bit sm, input bit sp);
    logic [6:0] f;
    bit adv;
    int exp_cnt;
    @(posedge r_clk); #1;
    r_rst_n = rn; r_start = st; r_stall = sl; r_flush = fl; r_halt = hl;
    r_step_mode = sm; r_step = sp;
    cyc++;
    f = '0;
    adv = !r_step_mode || r_step;
    if (!rn) begin
      m_started = 0; m_halt_seen = 0; m_since = 0; m_count = 0;
    end else if (!m_started) begin
      if (st) m_started = 1;
    end else if (m_halt_seen && m_since >= DRAIN) begin
      f = 7'b0000001;
    end else if (m_halt_seen) begin
      if (adv) begin f = 7'b0001100; m_since++; end
    end else begin
      f = 7'b0000010;
      if (adv) begin
        if (fl)      f = 7'b1111110;
        else if (hl) begin f = 7'b0001110; m_halt_seen = 1; m_since = 0; end
        else if (sl) f = 7'b0001110;
        else         f = 7'b1100110;
      end
    end
    exp_cnt = m_count;
    if (f[2] && m_count < MAXC) m_count++;
    sb_q.push_back({f, CW'(exp_cnt)});
  endtask

  always @(negedge r_clk) begin
    logic [7+CW-1:0] e, g;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = {w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_flush, w_back_en,
           w_running, w_halted, w_cycle_count};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got flags(pc,ifen,iffl,idfl,back,run,halt)=%b cnt=%0d expected flags=%b cnt=%0d",
                 cyc, g[7+CW-1:CW], g[CW-1:0], e[7+CW-1:CW], e[CW-1:0]);
      end
      if (w_running && w_halted) begin
        n_fail++;
        $display("FAIL exclusive cyc=%0d running and halted both 1, expected at most one", cyc);
      end
    end
  end

  initial begin
    bit sm;
    // Reset held with random inputs.
    for (int i = 0; i < 5; i++)
      cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1, 0, 0);   // flush beats halt
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);   // halt -> drain
    for (int i = 0; i < 6; i++)
      cycle(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    // Saturation, then reset mid-drain.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_SINGLE_STEP_EN
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, 0, 1, (i % 10) == 0);
`endif
    // Random episodes.
    for (int ep = 0; ep < 20; ep++) begin
      sm = 0;
`ifdef PIPE_SINGLE_STEP_EN
      sm = ($urandom_range(0, 2) == 0);
`endif
      cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        cycle(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++)
        cycle(1, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              sm, $urandom_range(0, 2) == 0);
    end
    @(negedge r_clk);
    @(negedge r_clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue got %0d pending entries, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
